keypad_scan: RTL and testbench

Scanner for a 4×4 matrix keypad used for amount and command entry on the coin charger front panel. It drives the keypad rows one at a time and samples the columns. It debounces the result over whole scan frames and emits one key event per confirmed press. It is the input-side counterpart of the multiplexed seven-segment digit driver and shares its time-multiplexed scanning scheme.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_scan_if.sv | 12 +
 rtl/keypad_row_drv.sv | 47 ++++
 rtl/keypad_scan.sv | 197 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NROWS = 4;
    localparam int unsigned NCOLS = 4;
    localparam int unsigned KEY_W = 4;
    localparam int unsigned RES_W = KEY_W + 1;

    // Bit 4 set marks an empty frame result.
    localparam logic [RES_W-1:0] KEY_NONE = 5'h10;

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StPressed,
        StDebRelease
    } key_state_e;

    // Lowest pressed column in one row, encoded as row*4+col, or KEY_NONE.
    function automatic logic [RES_W-1:0] row_code(input logic [1:0] row,
                                                  input logic [NCOLS-1:0] hit);
        logic [RES_W-1:0] code;
        code = KEY_NONE;
        for (int c = NCOLS - 1; c >= 0; c--) begin
            if (hit[c]) code = {1'b0, row, 2'(c)};
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Key event bundle produced by keypad_scan.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_held;

    modport master (output key_code, output key_valid, output key_held);
    modport slave  (input key_code, input key_valid, input key_held);

endinterface

// File: rtl/keypad_row_drv.sv
// Row slot timing: walks an active-low row strobe and flags sample and frame-end cycles.
module keypad_row_drv
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [NROWS-1:0] row_o,
    output logic [1:0]       row_idx_o,
    output logic             sample_o,
    output logic             frame_end_o
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] SlotLast = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0]  slot_q, slot_d;
    logic [NROWS-1:0] row_q, row_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic             slot_end;

    always_comb begin
        slot_end  = (slot_q == SlotLast);
        slot_d    = slot_end ? '0 : slot_q + 1'b1;
        row_d     = slot_end ? {row_q[NROWS-2:0], row_q[NROWS-1]} : row_q;
        row_idx_d = slot_end ? row_idx_q + 2'd1 : row_idx_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q    <= '0;
            row_q     <= 4'b1110;
            row_idx_q <= 2'd0;
        end else begin
            slot_q    <= slot_d;
            row_q     <= row_d;
            row_idx_q <= row_idx_d;
        end
    end

    assign row_o       = row_q;
    assign row_idx_o   = row_idx_q;
    assign sample_o    = slot_end;
    assign frame_end_o = slot_end && (row_idx_q == 2'd3);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with frame-level debounce; define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEB_SCANS    = 4,
    parameter int unsigned REPEAT_DELAY = 32,
    parameter int unsigned REPEAT_RATE  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NCOLS-1:0] COL,
    output logic [NROWS-1:0] ROW,
    keypad_scan_if.master    key_if
);

    localparam logic [3:0] DebN = 4'(DEB_SCANS);

    logic [NCOLS-1:0] col_s1_q, col_s2_q;
    logic [1:0]       row_idx;
    logic             sample, frame_end;
    logic [RES_W-1:0] best_q, best_d, frame_res;

    key_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d, cnt_inc;
    logic [KEY_W-1:0] cand_q, cand_d, code_q, code_d;
    logic             valid_q, valid_d, held_q, held_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RepDelay = (REPEAT_DELAY == 0) ? 1 : REPEAT_DELAY;
    localparam int unsigned RepRate  = (REPEAT_RATE == 0) ? 1 : REPEAT_RATE;

    logic [15:0] rep_cnt_q, rep_cnt_d, rep_inc, rep_target;
    logic        rep_first_q, rep_first_d;
`else
    if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_repeat_unused
    end
`endif

    keypad_row_drv #(
        .SCAN_DIV (SCAN_DIV)
    ) u_row_drv (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .row_o       (ROW),
        .row_idx_o   (row_idx),
        .sample_o    (sample),
        .frame_end_o (frame_end)
    );

    // Rows are visited in ascending order, so the first hit in a frame is the lowest code.
    always_comb begin
        frame_res = best_q;
        best_d    = best_q;
        if (sample) begin
            if (best_q == KEY_NONE) frame_res = row_code(row_idx, ~col_s2_q);
            best_d = frame_end ? KEY_NONE : frame_res;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_inc     = (rep_cnt_q == 16'hFFFF) ? rep_cnt_q : rep_cnt_q + 16'd1;
        rep_target  = rep_first_q ? 16'(RepDelay) : 16'(RepRate);
`endif
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_res != KEY_NONE) begin
                        cand_d = frame_res[KEY_W-1:0];
                        if (DEB_SCANS <= 1) begin
                            state_d = StPressed;
                            code_d  = frame_res[KEY_W-1:0];
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = StDebPress;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                StDebPress: begin
                    if (frame_res == {1'b0, cand_q}) begin
                        if (cnt_inc >= DebN) begin
                            state_d = StPressed;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    if (frame_res == {1'b0, code_q}) begin
`ifdef KEYPAD_REPEAT_EN
                        if (rep_inc >= rep_target) begin
                            valid_d     = 1'b1;
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b0;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
`endif
                    end else if (DEB_SCANS <= 1) begin
                        state_d = StIdle;
                        held_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDebRelease;
                        cnt_d   = 4'd1;
                    end
                end
                StDebRelease: begin
                    if (frame_res != {1'b0, code_q}) begin
                        if (cnt_inc >= DebN) begin
                            state_d = StIdle;
                            held_d  = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
`ifdef KEYPAD_REPEAT_EN
            // Repeat timing restarts from the confirm frame on every entry into PRESSED.
            if (state_d != StPressed || state_q != StPressed) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_s1_q <= '1;
            col_s2_q <= '1;
            best_q   <= KEY_NONE;
            state_q  <= StIdle;
            cnt_q    <= '0;
            cand_q   <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            col_s1_q <= COL;
            col_s2_q <= col_s1_q;
            best_q   <= best_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;
    assign key_if.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: directed key patterns, events checked by code and frame.
module tb_keypad_scan;

    localparam int unsigned SD    = 4;
    localparam int unsigned DEB   = 4;
    localparam int          FRAME = 4 * SD;

    typedef struct {
        int code;
        int frame;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] keys;
    int          cyc;
    int          checks;
    int          failures;
    exp_t        exp_q[$];

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_DIV     (SD),
        .DEB_SCANS    (DEB),
        .REPEAT_DELAY (32),
        .REPEAT_RATE  (8)
    ) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .COL    (col),
        .ROW    (row),
        .key_if (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since the last reset release; frame f spans cyc 16f..16f+15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Passive matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && kif.key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event_unexpected: got code=%0d frame=%0d, required no event",
                         kif.key_code, cyc / FRAME - 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (kif.key_code !== 4'(e.code) || (cyc / FRAME - 1) != e.frame) begin
                    failures++;
                    $display("FAIL event: got code=%0d frame=%0d, required code=%0d frame=%0d",
                             kif.key_code, cyc / FRAME - 1, e.code, e.frame);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic goto_frame(input int f);
        wait_cyc(f * FRAME);
    endtask

    task automatic expect_event(input int code, input int frame);
        exp_t e;
        e.code  = code;
        e.frame = frame;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        keys     = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_row", 32'(row), 32'hE);
        check("rst_code", 32'(kif.key_code), 32'h0);
        check("rst_valid", 32'(kif.key_valid), 32'h0);
        check("rst_held", 32'(kif.key_held), 32'h0);
        rst_n = 1'b1;

        check("row_c0", 32'(row), 32'hE);
        wait_cyc(3);  check("row_c3", 32'(row), 32'hE);
        wait_cyc(4);  check("row_c4", 32'(row), 32'hD);
        wait_cyc(8);  check("row_c8", 32'(row), 32'hB);
        wait_cyc(12); check("row_c12", 32'(row), 32'h7);
        wait_cyc(16); check("row_c16", 32'(row), 32'hE);

        // Clean press of key 9 (row2/col1), then release.
        goto_frame(1);  keys = 16'(1 << 9); expect_event(9, 4);
        goto_frame(4);  check("k9_held_before", 32'(kif.key_held), 32'h0);
        goto_frame(5);  check("k9_held", 32'(kif.key_held), 32'h1);
        check("k9_code", 32'(kif.key_code), 32'h9);
        goto_frame(6);  keys = '0;
        wait_cyc(9 * FRAME + FRAME - 1); check("k9_held_late", 32'(kif.key_held), 32'h1);
        goto_frame(10); check("k9_released", 32'(kif.key_held), 32'h0);
        check("k9_code_hold", 32'(kif.key_code), 32'h9);

        // Bouncing key 5, steady from frame 16.
        goto_frame(12); keys = 16'(1 << 5);
        goto_frame(13); keys = '0;
        goto_frame(14); keys = 16'(1 << 5);
        goto_frame(15); keys = '0;
        goto_frame(16); keys = 16'(1 << 5); expect_event(5, 19);
        goto_frame(19); check("k5_held_before", 32'(kif.key_held), 32'h0);
        goto_frame(20); check("k5_held", 32'(kif.key_held), 32'h1);
        check("k5_code", 32'(kif.key_code), 32'h5);
        keys = '0;
        goto_frame(24); check("k5_released", 32'(kif.key_held), 32'h0);

        // Keys 6 and 3 together resolve to 3.
        goto_frame(25); keys = 16'((1 << 6) | (1 << 3)); expect_event(3, 28);
        goto_frame(29); check("multi_held", 32'(kif.key_held), 32'h1);
        check("multi_code", 32'(kif.key_code), 32'h3);
        keys = '0;
        goto_frame(33); check("multi_released", 32'(kif.key_held), 32'h0);

        // Direct change from key 2 to key 14.
        goto_frame(34); keys = 16'(1 << 2); expect_event(2, 37);
        goto_frame(38); check("k2_code", 32'(kif.key_code), 32'h2);
        keys = 16'(1 << 14); expect_event(14, 45);
        goto_frame(41); check("chg_held_still", 32'(kif.key_held), 32'h1);
        goto_frame(42); check("chg_held_drop", 32'(kif.key_held), 32'h0);
        check("chg_code_old", 32'(kif.key_code), 32'h2);
        goto_frame(46); check("k14_held", 32'(kif.key_held), 32'h1);
        check("k14_code", 32'(kif.key_code), 32'hE);
        keys = '0;
        goto_frame(50); check("k14_released", 32'(kif.key_held), 32'h0);

        // Long hold of key 0 for 60 frames.
        goto_frame(51); keys = 16'h0001; expect_event(0, 54);
`ifdef KEYPAD_REPEAT_EN
        expect_event(0, 86);
        expect_event(0, 94);
        expect_event(0, 102);
        expect_event(0, 110);
`endif
        goto_frame(80); check("k0_held", 32'(kif.key_held), 32'h1);
        goto_frame(111); keys = '0;
        goto_frame(115); check("k0_released", 32'(kif.key_held), 32'h0);

        // Reset in the middle of a press debounce: no event may follow.
        goto_frame(117); keys = 16'(1 << 7);
        wait_cyc(119 * FRAME + 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_row", 32'(row), 32'hE);
        check("mid_rst_held", 32'(kif.key_held), 32'h0);
        check("mid_rst_valid", 32'(kif.key_valid), 32'h0);
        @(negedge clk);
        keys  = '0;
        rst_n = 1'b1;
        goto_frame(6);
        check("mid_rst_no_hold", 32'(kif.key_held), 32'h0);
        check("events_pending", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
